run_sequencer: RTL

Synthesizable host-side controller for the processor's start/halt launch protocol. It clears and preloads data memory, holds the core in `start`, releases it, and waits for `halt`. It then reads the result bytes back and reports them with a run-cycle count. It sits beside `TopLevel` and owns the data-memory port whenever the core is not running.

---
 rtl/run_seq_pkg.sv | 23 ++
 rtl/byte_cursor.sv | 31 +++
 rtl/run_sequencer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/run_seq_pkg.sv
// Shared types and default constants for the run sequencer.
// The state enum is also visible to anything that wants to decode sequencer state.
package run_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StLoad,
    StLaunch,
    StRun,
    StRead,
    StDone
  } state_e;

  localparam int unsigned DefOpBase  = 1;
  localparam int unsigned DefResBase = 5;
  localparam int unsigned DefTimeout = 100000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/byte_cursor.sv
// Loadable up-counter with a terminal-count flag.
// The sequencer reuses it as the per-phase byte/cycle index.
module byte_cursor #(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_inc,
  input  logic [W-1:0] i_last,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_inc) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == i_last);

endmodule

// File: rtl/run_sequencer.sv
// Host-side launch controller: clears and preloads data memory, releases the core,
// waits for halt, then reads the result bytes back with a run-cycle count.
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int unsigned AW         = 8,
  parameter int unsigned N_OPS      = 4,
  parameter int unsigned N_RES      = 4,
  parameter int unsigned OP_BASE    = DefOpBase,
  parameter int unsigned RES_BASE   = DefResBase,
  parameter int unsigned START_HOLD = 2,
  parameter int unsigned TIMEOUT    = DefTimeout
) (
  input  logic               CLK,
  input  logic               rst_n,
  input  logic               go,
  input  logic [N_OPS*8-1:0] op_data,
  output logic               dut_start,
  input  logic               dut_halt,
  output logic               mem_own,
  output logic               mem_we,
  output logic [AW-1:0]      mem_addr,
  output logic [7:0]         mem_wdata,
  input  logic [7:0]         mem_rdata,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic [N_RES*8-1:0] result,
  output logic [31:0]        cycles
);

  localparam int unsigned CW = max_u(AW, max_u($clog2(N_OPS + 1),
                                     max_u($clog2(N_RES + 1), $clog2(START_HOLD + 1))));

  localparam logic [CW-1:0] LastClear = CW'(2 ** AW - 1);
  localparam logic [CW-1:0] LastOps   = CW'(N_OPS - 1);
  localparam logic [CW-1:0] LastRes   = CW'(N_RES - 1);
  localparam logic [CW-1:0] LastHold  = CW'(START_HOLD - 1);

  state_e               r_state, w_state_nx;
  logic                 r_dut_start, r_mem_own, r_mem_we, r_busy, r_done, r_timeout;
  logic [AW-1:0]        r_mem_addr;
  logic [7:0]           r_mem_wdata;
  logic [N_RES*8-1:0]   r_result;
  logic [31:0]          r_cycles;

  logic                 w_mem_we_nx, w_timeout_nx;
  logic [AW-1:0]        w_mem_addr_nx;
  logic [7:0]           w_mem_wdata_nx;
  logic [N_RES*8-1:0]   w_result_nx;
  logic [31:0]          w_cycles_nx;

  logic                 w_cur_load, w_cur_inc, w_cur_tc;
  logic [CW-1:0]        w_cur_last, w_cur_cnt;

  byte_cursor #(
    .W (CW)
  ) u_cursor (
    .i_clk      (CLK),
    .i_rst_n    (rst_n),
    .i_load     (w_cur_load),
    .i_load_val (CW'(0)),
    .i_inc      (w_cur_inc),
    .i_last     (w_cur_last),
    .o_cnt      (w_cur_cnt),
    .o_tc       (w_cur_tc)
  );

  // Operand byte idx, MSB first.
  function automatic logic [7:0] op_byte(input logic [CW-1:0] idx);
    return op_data[8*(N_OPS-1-32'(idx)) +: 8];
  endfunction

  // Outputs are registered, so this block computes the values for the next cycle.
  always_comb begin
    w_state_nx     = r_state;
    w_cur_load     = 1'b0;
    w_cur_inc      = 1'b0;
    w_cur_last     = '0;
    w_mem_we_nx    = 1'b0;
    w_mem_addr_nx  = r_mem_addr;
    w_mem_wdata_nx = 8'h00;
    w_timeout_nx   = r_timeout;
    w_result_nx    = r_result;
    w_cycles_nx    = r_cycles;
    unique case (r_state)
      StIdle: begin
        if (go) begin
          w_state_nx    = StClear;
          w_cur_load    = 1'b1;
          w_timeout_nx  = 1'b0;
          w_cycles_nx   = '0;
          w_result_nx   = '0;
          w_mem_we_nx   = 1'b1;
          w_mem_addr_nx = '0;
        end
      end
      StClear: begin
        w_cur_last  = LastClear;
        w_mem_we_nx = 1'b1;
        if (w_cur_tc) begin
          w_state_nx     = StLoad;
          w_cur_load     = 1'b1;
          w_mem_addr_nx  = AW'(OP_BASE);
          w_mem_wdata_nx = op_byte(CW'(0));
        end else begin
          w_cur_inc     = 1'b1;
          w_mem_addr_nx = r_mem_addr + AW'(1);
        end
      end
      StLoad: begin
        w_cur_last = LastOps;
        if (w_cur_tc) begin
          w_state_nx = StLaunch;
          w_cur_load = 1'b1;
        end else begin
          w_cur_inc      = 1'b1;
          w_mem_we_nx    = 1'b1;
          w_mem_addr_nx  = r_mem_addr + AW'(1);
          w_mem_wdata_nx = op_byte(w_cur_cnt + CW'(1));
        end
      end
      StLaunch: begin
        w_cur_last = LastHold;
        if (w_cur_tc) begin
          w_state_nx = StRun;
          w_cur_load = 1'b1;
        end else begin
          w_cur_inc = 1'b1;
        end
      end
      StRun: begin
        w_cycles_nx = r_cycles + 32'd1;
        // r_cycles == 0 marks the first RUN cycle, where a stale halt is ignored.
        if (dut_halt && (r_cycles != 32'd0)) begin
          w_state_nx    = StRead;
          w_cur_load    = 1'b1;
          w_mem_addr_nx = AW'(RES_BASE);
        end else if (w_cycles_nx == TIMEOUT) begin
          w_state_nx   = StDone;
          w_timeout_nx = 1'b1;
          w_result_nx  = '0;
        end
      end
      StRead: begin
        w_cur_last = LastRes;
        w_result_nx[8*(N_RES-1-32'(w_cur_cnt)) +: 8] = mem_rdata;
        if (w_cur_tc) begin
          w_state_nx = StDone;
          w_cur_load = 1'b1;
        end else begin
          w_cur_inc     = 1'b1;
          w_mem_addr_nx = r_mem_addr + AW'(1);
        end
      end
      StDone: begin
        w_state_nx = StIdle;
      end
      default: begin
        w_state_nx = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_dut_start <= 1'b1;
      r_mem_own   <= 1'b1;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 8'h00;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
      r_result    <= '0;
      r_cycles    <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_dut_start <= (w_state_nx != StRun);
      r_mem_own   <= (w_state_nx != StRun);
      r_mem_we    <= w_mem_we_nx;
      r_mem_addr  <= w_mem_addr_nx;
      r_mem_wdata <= w_mem_wdata_nx;
      r_busy      <= (w_state_nx != StIdle);
      r_done      <= (w_state_nx == StDone);
      r_timeout   <= w_timeout_nx;
      r_result    <= w_result_nx;
      r_cycles    <= w_cycles_nx;
    end
  end

  assign dut_start = r_dut_start;
  assign mem_own   = r_mem_own;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;
  assign done      = r_done;
  assign timeout   = r_timeout;
  assign result    = r_result;
  assign cycles    = r_cycles;

endmodule
